// File: rtl/ysyx_24120009_bus_sched_pkg.sv
// Shared definitions for the memory-port scheduler: FSM encodings, default
// watchdog depth, requester indices and the direction-aware completion select.
package ysyx_24120009_bus_sched_pkg;

  localparam logic [1:0] ysyx_24120009_SCHED_IDLE    = 2'd0;
  localparam logic [1:0] ysyx_24120009_SCHED_BUSY    = 2'd1;
  localparam logic [1:0] ysyx_24120009_SCHED_RELEASE = 2'd2;

  localparam int ysyx_24120009_TIMEOUT_DEFAULT = 1024;

  localparam int ysyx_24120009_REQ_IFU = 0;
  localparam int ysyx_24120009_REQ_MEM = 1;

  // Only the handshake matching the latched direction can end a transaction.
  function automatic logic sel_done(input logic i_wr_dir,
                                    input logic i_rd_done,
                                    input logic i_wr_done);
    return i_wr_dir ? i_wr_done : i_rd_done;
  endfunction

endpackage

// File: rtl/ysyx_24120009_bus_sched_rr_pick.sv
// Rotating priority encoder: first set request at or above i_rr_ptr, wrapping
// back to index 0. Wrap is an explicit compare so N_REQ need not be a power of 2.
module ysyx_24120009_rr_pick #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic             o_found,
  output logic [ID_W-1:0]  o_winner
);

  logic [ID_W:0] w_idx;

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, i_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(N_REQ);
      end
      if (!o_found && i_req[w_idx[ID_W-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ysyx_24120009_bus_sched.sv
// Round-robin owner scheduler for the single AXI4-Lite memory port, with a
// watchdog that force-releases a transaction whose response never arrives.
module ysyx_24120009_bus_sched
  import ysyx_24120009_bus_sched_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ID_W           = 1,
  parameter int TIMEOUT_CYCLES = ysyx_24120009_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_wr,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             bus_wr,
  input  logic             rd_done,
  input  logic             wr_done,
  output logic             txn_done,
  output logic             timeout,
  output logic [ID_W-1:0]  err_id,
  output logic             err_flag,
  output logic [1:0]       sched_state_debug
);

  // Handshake contract: req is a level held by a requester until it sees
  // txn_done (or its grant vanishes on timeout); a grant is held from the
  // cycle after selection until the direction-matching done handshake.
  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_bus_wr;
  logic             r_timeout;
  logic [ID_W-1:0]  r_err_id;
  logic             r_err_flag;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_found;
  logic [ID_W-1:0]  w_winner;
  logic [N_REQ-1:0] w_onehot;
  logic             w_busy;
  logic             w_done;
  logic             w_thresh;
  logic [ID_W-1:0]  w_next_ptr;

  ysyx_24120009_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  assign w_busy     = (r_state == ysyx_24120009_SCHED_BUSY);
  assign w_done     = w_busy && sel_done(r_bus_wr, rd_done, wr_done);
  assign w_thresh   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_next_ptr = (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ysyx_24120009_SCHED_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_bus_wr   <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_id   <= '0;
      r_err_flag <= 1'b0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ysyx_24120009_SCHED_IDLE: begin
          if (w_found) begin
            r_state  <= ysyx_24120009_SCHED_BUSY;
            r_gnt    <= w_onehot;
            r_gnt_id <= w_winner;
            r_bus_wr <= req_wr[w_winner];
            r_cnt    <= '0;
          end
        end
        ysyx_24120009_SCHED_BUSY: begin
          // Completion takes precedence over a watchdog expiry in the same cycle.
          if (w_done) begin
            r_state  <= ysyx_24120009_SCHED_RELEASE;
            r_gnt    <= '0;
            r_rr_ptr <= w_next_ptr;
          end else if (w_thresh) begin
            r_state    <= ysyx_24120009_SCHED_RELEASE;
            r_gnt      <= '0;
            r_rr_ptr   <= w_next_ptr;
            r_timeout  <= 1'b1;
            r_err_flag <= 1'b1;
            r_err_id   <= r_gnt_id;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ysyx_24120009_SCHED_RELEASE: begin
          r_state <= ysyx_24120009_SCHED_IDLE;
        end
        default: begin
          r_state <= ysyx_24120009_SCHED_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt               = r_gnt;
  assign gnt_valid         = |r_gnt;
  assign gnt_id            = r_gnt_id;
  assign bus_wr            = r_bus_wr;
  assign txn_done          = w_done;
  assign timeout           = r_timeout;
  assign err_id            = r_err_id;
  assign err_flag          = r_err_flag;
  assign sched_state_debug = r_state;

endmodule

// File: tb/tb_ysyx_24120009_bus_sched.sv
// Directed bench for the memory-port scheduler: reset, rotation, direction
// filtering, watchdog expiry and asynchronous reset during a transaction.
module tb_ysyx_24120009_bus_sched;

  localparam int N_REQ = 2;
  localparam int ID_W  = 1;
  localparam int TMO   = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_wr;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic             bus_wr;
  logic             rd_done;
  logic             wr_done;
  logic             txn_done;
  logic             timeout;
  logic [ID_W-1:0]  err_id;
  logic             err_flag;
  logic [1:0]       sched_state_debug;

  int n_checks;
  int n_errors;

  ysyx_24120009_bus_sched #(
    .N_REQ          (N_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_wr            (req_wr),
    .gnt               (gnt),
    .gnt_valid         (gnt_valid),
    .gnt_id            (gnt_id),
    .bus_wr            (bus_wr),
    .rd_done           (rd_done),
    .wr_done           (wr_done),
    .txn_done          (txn_done),
    .timeout           (timeout),
    .err_id            (err_id),
    .err_flag          (err_flag),
    .sched_state_debug (sched_state_debug)
  );

  // Clock / reset-independent time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_gnt_valid"}, 32'(gnt_valid), 32'd0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    chk({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
    chk({tag, "_txn_done"}, 32'(txn_done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_err_id"}, 32'(err_id), 32'd0);
    chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
    chk({tag, "_state"}, 32'(sched_state_debug), 32'd0);
  endtask

  // Called in an IDLE cycle with req already set; returns in the next IDLE cycle.
  task automatic run_txn(input int exp_id, input bit wr, input int d);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[exp_id] = 1'b1;
    cyc();
    chk("grant_gnt", 32'(gnt), 32'(oh));
    chk("grant_id", 32'(gnt_id), 32'(exp_id));
    chk("grant_wr", 32'(bus_wr), 32'(wr));
    chk("grant_valid", 32'(gnt_valid), 32'd1);
    chk("grant_state", 32'(sched_state_debug), 32'd1);
    chk("onehot", 32'($countones(gnt)), 32'd1);
    for (int k = 2; k <= d; k++) begin
      cyc();
      chk("hold_gnt", 32'(gnt), 32'(oh));
      chk("hold_txn_done", 32'(txn_done), 32'd0);
    end
    if (wr) wr_done = 1'b1;
    else    rd_done = 1'b1;
    #1;
    chk("txn_done", 32'(txn_done), 32'd1);
    cyc();
    rd_done = 1'b0;
    wr_done = 1'b0;
    chk("rel_gnt", 32'(gnt), 32'd0);
    chk("rel_state", 32'(sched_state_debug), 32'd2);
    chk("rel_txn_done", 32'(txn_done), 32'd0);
    chk("rel_timeout", 32'(timeout), 32'd0);
    cyc();
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_state", 32'(sched_state_debug), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    req      = '0;
    req_wr   = '0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    repeat (2) cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();
    chk("idle_noreq_gnt", 32'(gnt), 32'd0);
    chk("idle_noreq_state", 32'(sched_state_debug), 32'd0);

    // Single read from requester 0, done on the third BUSY cycle
    req = 2'b01;
    run_txn(0, 1'b0, 3);

    // Pointer now 1: contention grants 1,0,1,0
    req = 2'b11;
    run_txn(1, 1'b0, 3);
    run_txn(0, 1'b0, 3);
    run_txn(1, 1'b0, 3);
    run_txn(0, 1'b0, 3);

    // Direction filter: write owner ignores rd_done
    req    = 2'b10;
    req_wr = 2'b10;
    cyc();
    chk("dir_gnt", 32'(gnt), 32'h2);
    chk("dir_bus_wr", 32'(bus_wr), 32'd1);
    rd_done = 1'b1;
    #1;
    chk("dir_rd_ignored", 32'(txn_done), 32'd0);
    cyc();
    rd_done = 1'b0;
    chk("dir_still_busy", 32'(sched_state_debug), 32'd1);
    chk("dir_still_gnt", 32'(gnt), 32'h2);
    wr_done = 1'b1;
    #1;
    chk("dir_wr_done", 32'(txn_done), 32'd1);
    cyc();
    wr_done = 1'b0;
    req     = 2'b00;
    chk("dir_rel_state", 32'(sched_state_debug), 32'd2);
    cyc();
    chk("dir_hold_bus_wr", 32'(bus_wr), 32'd1);
    chk("dir_hold_gnt_id", 32'(gnt_id), 32'd1);

    // Watchdog: pointer back to 0, only requester 1 asks, no done
    req    = 2'b10;
    req_wr = 2'b00;
    cyc();
    chk("wd_gnt", 32'(gnt), 32'h2);
    chk("wd_bus_wr_new", 32'(bus_wr), 32'd0);
    chk("wd_err_flag_pre", 32'(err_flag), 32'd0);
    for (int k = 2; k <= TMO; k++) begin
      cyc();
      chk("wd_busy_gnt", 32'(gnt), 32'h2);
      chk("wd_no_timeout", 32'(timeout), 32'd0);
    end
    cyc();
    req = 2'b00;
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_gnt_drop", 32'(gnt), 32'd0);
    chk("wd_state", 32'(sched_state_debug), 32'd2);
    chk("wd_err_flag", 32'(err_flag), 32'd1);
    chk("wd_err_id", 32'(err_id), 32'd1);
    chk("wd_txn_done", 32'(txn_done), 32'd0);
    cyc();
    chk("wd_timeout_pulse", 32'(timeout), 32'd0);
    chk("wd_err_sticky", 32'(err_flag), 32'd1);
    chk("wd_idle", 32'(sched_state_debug), 32'd0);

    // Done on the threshold cycle: completion wins over the watchdog
    req = 2'b01;
    cyc();
    chk("wd2_gnt", 32'(gnt), 32'h1);
    for (int k = 2; k <= TMO; k++) cyc();
    chk("wd2_still_busy", 32'(sched_state_debug), 32'd1);
    rd_done = 1'b1;
    #1;
    chk("wd2_txn_done", 32'(txn_done), 32'd1);
    cyc();
    rd_done = 1'b0;
    req     = 2'b00;
    chk("wd2_no_timeout", 32'(timeout), 32'd0);
    chk("wd2_state", 32'(sched_state_debug), 32'd2);
    chk("wd2_err_flag", 32'(err_flag), 32'd1);
    chk("wd2_err_id", 32'(err_id), 32'd1);
    cyc();

    // Asynchronous reset in the middle of a write owned by requester 1
    req    = 2'b10;
    req_wr = 2'b10;
    cyc();
    chk("rst_pre_gnt", 32'(gnt), 32'h2);
    chk("rst_pre_bus_wr", 32'(bus_wr), 32'd1);
    cyc();
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    cyc();
    cyc();
    chk_all_zero("rst_held");
    rst    = 1'b0;
    req    = 2'b10;
    req_wr = 2'b00;
    cyc();
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_id", 32'(gnt_id), 32'd1);
    chk("post_rst_bus_wr", 32'(bus_wr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
